// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// reset level, stall vector encodings and the controller FSM states.
package stall_ctrl_pkg;

  localparam logic RST_ENABLE = 1'b1;

  // Stall vector bits: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MCYC  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/stall_ctrl_sat_counter.sv
// Saturating up-counter used for the optional performance counters.
// Clears on synchronous active-high rst; holds at all-ones once reached.
module sat_counter
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Count up on inc, stop at the maximum value.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller for the five-stage core.
// Merges decode/execute stall requests, sequences multi-cycle execute
// operations and issues a one-cycle flush with a redirect PC.
// Optional feature macro: STALL_CTRL_PERF_EN (stall-cycle and flush
// performance counters; ports read 0 when undefined).
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MC_LEN_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id_i,
  input  logic                stallreq_ex_i,
  input  logic                mc_start_i,
  input  logic [MC_LEN_W-1:0] mc_len_i,
  input  logic                flush_req_i,
  input  logic [31:0]         flush_pc_i,
  output logic [5:0]          stall_o,
  output logic                flush_o,
  output logic [31:0]         new_pc_o,
  output logic                mc_done_o,
  output logic                busy_o,
  output logic [31:0]         perf_stall_cyc_o,
  output logic [15:0]         perf_flush_cnt_o
);

  localparam logic [MC_LEN_W-1:0] CNT_ONE = MC_LEN_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [MC_LEN_W-1:0] r_cnt;
  logic [MC_LEN_W-1:0] w_cnt_nxt;
  logic [31:0]         r_new_pc;
  logic [31:0]         w_new_pc_nxt;
  logic                r_flush;
  logic                w_mc_done;
  logic                w_mc_go;
  logic                w_mc_hold;

  assign w_mc_go   = (r_state == ST_IDLE) && mc_start_i && (mc_len_i != '0);
  assign w_mc_hold = (r_state == ST_MCYC) && (r_cnt > CNT_ONE);

  // Next-state, counter and redirect-PC logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_new_pc_nxt = r_new_pc;
    w_mc_done    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (flush_req_i) begin
          w_state_nxt  = ST_FLUSH;
          w_new_pc_nxt = flush_pc_i;
        end else if (w_mc_go) begin
          w_state_nxt = ST_MCYC;
          w_cnt_nxt   = mc_len_i;
        end
      end
      ST_MCYC: begin
        if (flush_req_i) begin
          w_state_nxt  = ST_FLUSH;
          w_cnt_nxt    = '0;
          w_new_pc_nxt = flush_pc_i;
        end else if (r_cnt == CNT_ONE) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_mc_done   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Stall vector priority: flush overrides everything, then ex-level holds.
  always_comb begin
    stall_o = STALL_NONE;
    if (r_state == ST_FLUSH) begin
      stall_o = STALL_NONE;
    end else if (flush_req_i) begin
      stall_o = STALL_NONE;
    end else if (w_mc_hold || w_mc_go) begin
      stall_o = STALL_EX;
    end else if (stallreq_ex_i) begin
      stall_o = STALL_EX;
    end else if (stallreq_id_i) begin
      stall_o = STALL_ID;
    end
  end

  // State register, countdown, captured PC and registered flush strobe.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_new_pc <= '0;
      r_flush  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_new_pc <= w_new_pc_nxt;
      r_flush  <= (w_state_nxt == ST_FLUSH);
    end
  end

  // Completion is suppressed in a reset cycle so a reset never leaks a done pulse.
  assign mc_done_o = w_mc_done && (rst != RST_ENABLE);
  assign flush_o   = r_flush;
  assign new_pc_o  = r_new_pc;
  assign busy_o    = (r_state != ST_IDLE);

`ifdef STALL_CTRL_PERF_EN
  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_o[0]),
    .count (perf_stall_cyc_o)
  );

  sat_counter #(.WIDTH(16)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (r_flush),
    .count (perf_flush_cnt_o)
  );
`else
  assign perf_stall_cyc_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: the driver pushes hand-computed expected
// outputs per cycle; a negedge monitor pops and compares.
module tb_stall_ctrl;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;

`ifdef STALL_CTRL_PERF_EN
  localparam logic [31:0] PERF_ST_EXP = 32'd8;
  localparam logic [15:0] PERF_FL_EXP = 16'd2;
`else
  localparam logic [31:0] PERF_ST_EXP = 32'd0;
  localparam logic [15:0] PERF_FL_EXP = 16'd0;
`endif

  logic        clk;
  logic        rst;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        mc_start_i;
  logic [5:0]  mc_len_i;
  logic        flush_req_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        mc_done_o;
  logic        busy_o;
  logic [31:0] perf_stall_cyc_o;
  logic [15:0] perf_flush_cnt_o;

  stall_ctrl #(.MC_LEN_W(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_id_i    (stallreq_id_i),
    .stallreq_ex_i    (stallreq_ex_i),
    .mc_start_i       (mc_start_i),
    .mc_len_i         (mc_len_i),
    .flush_req_i      (flush_req_i),
    .flush_pc_i       (flush_pc_i),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .new_pc_o         (new_pc_o),
    .mc_done_o        (mc_done_o),
    .busy_o           (busy_o),
    .perf_stall_cyc_o (perf_stall_cyc_o),
    .perf_flush_cnt_o (perf_flush_cnt_o)
  );

  typedef struct {
    int          idx;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] npc;
    logic        done;
    logic        busy;
    logic        pchk;
    logic [31:0] pst;
    logic [15:0] pfl;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_push = 0;
  logic        pchk_req = 1'b0;
  logic [31:0] pst_req  = '0;
  logic [15:0] pfl_req  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic vec(input logic r, input logic id, input logic ex, input logic ms,
                     input logic [5:0] len, input logic fr, input logic [31:0] pc,
                     input logic [5:0] es, input logic ef, input logic [31:0] enp,
                     input logic ed, input logic eb);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stallreq_id_i = id; stallreq_ex_i = ex; mc_start_i = ms;
    mc_len_i = len; flush_req_i = fr; flush_pc_i = pc;
    e.idx = n_push; e.stall = es; e.flush = ef; e.npc = enp; e.done = ed; e.busy = eb;
    e.pchk = pchk_req; e.pst = pst_req; e.pfl = pfl_req;
    pchk_req = 1'b0;
    n_push++;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [31:0] enp);
    vec(0, 0, 0, 0, 6'd0, 0, 32'h0, S0, 0, enp, 0, 0);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (stall_o !== e.stall || flush_o !== e.flush || new_pc_o !== e.npc ||
          mc_done_o !== e.done || busy_o !== e.busy) begin
        n_err++;
        $display("FAIL vec%0d: got stall=%b flush=%b npc=%h done=%b busy=%b, want stall=%b flush=%b npc=%h done=%b busy=%b",
                 e.idx, stall_o, flush_o, new_pc_o, mc_done_o, busy_o,
                 e.stall, e.flush, e.npc, e.done, e.busy);
      end
      if (e.pchk) begin
        n_vec++;
        if (perf_stall_cyc_o !== e.pst || perf_flush_cnt_o !== e.pfl) begin
          n_err++;
          $display("FAIL perf@vec%0d: got stall_cyc=%0d flush_cnt=%0d, want stall_cyc=%0d flush_cnt=%0d",
                   e.idx, perf_stall_cyc_o, perf_flush_cnt_o, e.pst, e.pfl);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stallreq_id_i = 0; stallreq_ex_i = 0; mc_start_i = 0;
    mc_len_i = '0; flush_req_i = 0; flush_pc_i = '0;
    repeat (2) @(posedge clk);

    // Reset state
    vec(1, 0, 0, 0, 6'd0, 0, 32'h0, S0, 0, 32'h0, 0, 0);

    // Single-cycle stalls, zero latency
    vec(0, 1, 0, 0, 6'd0, 0, 32'h0, SI, 0, 32'h0, 0, 0);
    idle(32'h0);
    vec(0, 1, 1, 0, 6'd0, 0, 32'h0, SE, 0, 32'h0, 0, 0);
    vec(0, 0, 1, 0, 6'd0, 0, 32'h0, SE, 0, 32'h0, 0, 0);

    // mc_len=0 is ignored
    vec(0, 0, 0, 1, 6'd0, 0, 32'h0, S0, 0, 32'h0, 0, 0);
    idle(32'h0);

    // mc_len=4: four held cycles, done on the fifth; restart ignored in MCYC
    vec(0, 0, 0, 1, 6'd4, 0, 32'h0, SE, 0, 32'h0, 0, 0);
    vec(0, 0, 0, 0, 6'd0, 0, 32'h0, SE, 0, 32'h0, 0, 1);
    vec(0, 0, 0, 1, 6'd9, 0, 32'h0, SE, 0, 32'h0, 0, 1);
    vec(0, 0, 0, 0, 6'd0, 0, 32'h0, SE, 0, 32'h0, 0, 1);
    vec(0, 0, 0, 0, 6'd0, 0, 32'h0, S0, 0, 32'h0, 1, 1);
    idle(32'h0);

    // mc_len=10 aborted by flush in cycle 3; requests ignored during FLUSH
    vec(0, 0, 0, 1, 6'd10, 0, 32'h0,   SE, 0, 32'h0,   0, 0);
    vec(0, 0, 0, 0, 6'd0,  0, 32'h0,   SE, 0, 32'h0,   0, 1);
    vec(0, 0, 0, 0, 6'd0,  1, 32'h120, S0, 0, 32'h0,   0, 1);
    vec(0, 1, 0, 0, 6'd0,  1, 32'h999, S0, 1, 32'h120, 0, 1);
    idle(32'h120);
    idle(32'h120);

    // Flush from IDLE wins over a simultaneous mc_start
    vec(0, 0, 0, 1, 6'd3, 1, 32'hDEAD_BEEC, S0, 0, 32'h120,       0, 0);
    vec(0, 0, 0, 0, 6'd0, 0, 32'h0,         S0, 1, 32'hDEAD_BEEC, 0, 1);
    idle(32'hDEAD_BEEC);

    // Reset in cycle 2 of mc_len=6: everything clears, no done pulse
    vec(0, 0, 0, 1, 6'd6, 0, 32'h0, SE, 0, 32'hDEAD_BEEC, 0, 0);
    vec(1, 0, 0, 0, 6'd0, 0, 32'h0, SE, 0, 32'hDEAD_BEEC, 0, 1);
    for (int i = 0; i < 7; i++) idle(32'h0);

    // Minimum length op
    vec(0, 0, 0, 1, 6'd1, 0, 32'h0, SE, 0, 32'h0, 0, 0);
    vec(0, 0, 0, 0, 6'd0, 0, 32'h0, S0, 0, 32'h0, 1, 1);
    idle(32'h0);

    // Flush arriving exactly on the completing cycle suppresses done
    vec(0, 0, 0, 1, 6'd2, 0, 32'h0,  SE, 0, 32'h0,  0, 0);
    vec(0, 0, 0, 0, 6'd0, 0, 32'h0,  SE, 0, 32'h0,  0, 1);
    vec(0, 0, 0, 0, 6'd0, 1, 32'h40, S0, 0, 32'h0,  0, 1);
    vec(0, 0, 0, 0, 6'd0, 0, 32'h0,  S0, 1, 32'h40, 0, 1);
    idle(32'h40);

    // Maximum length op (63)
    vec(0, 0, 0, 1, 6'd63, 0, 32'h0, SE, 0, 32'h40, 0, 0);
    for (int i = 0; i < 62; i++) vec(0, 0, 0, 0, 6'd0, 0, 32'h0, SE, 0, 32'h40, 0, 1);
    vec(0, 0, 0, 0, 6'd0, 0, 32'h0, S0, 0, 32'h40, 1, 1);
    idle(32'h40);

    // Performance counters: 3 ID stalls + mc_len=5 + 2 flushes
    vec(1, 0, 0, 0, 6'd0, 0, 32'h0, S0, 0, 32'h40, 0, 0);
    pchk_req = 1'b1; pst_req = 32'd0; pfl_req = 16'd0;
    idle(32'h0);
    for (int i = 0; i < 3; i++) vec(0, 1, 0, 0, 6'd0, 0, 32'h0, SI, 0, 32'h0, 0, 0);
    vec(0, 0, 0, 1, 6'd5, 0, 32'h0, SE, 0, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++) vec(0, 0, 0, 0, 6'd0, 0, 32'h0, SE, 0, 32'h0, 0, 1);
    vec(0, 0, 0, 0, 6'd0, 0, 32'h0, S0, 0, 32'h0, 1, 1);
    vec(0, 0, 0, 0, 6'd0, 1, 32'h10, S0, 0, 32'h0,  0, 0);
    vec(0, 0, 0, 0, 6'd0, 0, 32'h0,  S0, 1, 32'h10, 0, 1);
    idle(32'h10);
    vec(0, 0, 0, 0, 6'd0, 1, 32'h20, S0, 0, 32'h10, 0, 0);
    vec(0, 0, 0, 0, 6'd0, 0, 32'h0,  S0, 1, 32'h20, 0, 1);
    pchk_req = 1'b1; pst_req = PERF_ST_EXP; pfl_req = PERF_FL_EXP;
    idle(32'h20);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    if (n_vec != n_push + 2) begin
      n_err++;
      $display("FAIL count: checked %0d, want %0d", n_vec, n_push + 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
